// File: rtl/rr_mux_nx1_if.sv
// rr_mux_nx1_if: handshake bundle between N producers, the mux and one consumer
interface rr_mux_nx1_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [WIDTH-1:0]  out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: N-channel registered valid/ready mux with fixed or round-robin grant
module rr_mux_nx1 #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input logic         clk,
    input logic         rst,
    rr_mux_nx1_if.slave bus
);
    localparam int SELW = $clog2(N);
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            load_en;
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] p, input int i);
        int j;
        j = int'(p) + i;
        return SELW'(j >= N ? j - N : j);
    endfunction
    // Reset blocks acceptance so no producer sees a handshake whose word is discarded
    assign load_en = !rst && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = (load_en && gnt_any) ? (N'(1) << gnt_idx) : '0;
    // Grant: fixed channel, or first valid channel scanning upward from rr_ptr
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!bus.mode) begin
            gnt_any = (int'(bus.sel) < N) && bus.in_valid[bus.sel];
            gnt_idx = bus.sel;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (bus.in_valid[wrap_add(rr_ptr, i)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = wrap_add(rr_ptr, i);
                end
            end
        end
    end
    // Output register with same-cycle replacement; pointer advances past the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            rr_ptr        <= '0;
        end else if (load_en) begin
            bus.out_valid <= gnt_any;
            if (gnt_any) begin
                bus.out_data <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
                bus.out_ch   <= gnt_idx;
                if (bus.mode)
                    rr_ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule
